// File: rtl/microprog_sequencer.sv
// Microprogram sequencer: pops one FIFO entry and issues its command words to the PIM array.
// Optional wait-for-done timeout with sticky error is built only when SEQ_TIMEOUT_EN is defined.
module microprog_sequencer #(
  parameter  int MICROPROG_LEN_WORDS = 4,
  parameter  int CMD_SIZE_BITS       = 64,
  parameter  int TIMEOUT_CYCLES      = 1024,
  localparam int IDX_W = (MICROPROG_LEN_WORDS > 1) ? $clog2(MICROPROG_LEN_WORDS) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         enable,
  input  logic                                         fifo_empty,
  output logic                                         fifo_read_en,
  input  logic [CMD_SIZE_BITS*MICROPROG_LEN_WORDS-1:0] fifo_read_data,
  output logic                                         cmd_valid,
  output logic [CMD_SIZE_BITS-1:0]                     cmd_data,
  input  logic                                         cmd_ready,
  input  logic                                         cmd_done,
  output logic                                         busy,
  output logic                                         prog_done,
  output logic [IDX_W-1:0]                             word_idx,
  output logic [15:0]                                  progs_completed,
  output logic                                         error,
  input  logic                                         err_clr
);

  // state | meaning
  // IDLE  | waiting for enable and a non-empty FIFO
  // FETCH | one-cycle pop request
  // LOAD  | capture entry, present word 0
  // ISSUE | cmd_valid held until cmd_ready
  // WAIT  | waiting for cmd_done of the accepted word
  // DONE  | program complete pulse, bump counter
  // ERROR | timeout seen, sticky until err_clr
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] ISSUE = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] ERROR = 3'd6;

  logic [2:0]                                   state;
  logic [CMD_SIZE_BITS*MICROPROG_LEN_WORDS-1:0] entry;
  logic [CMD_SIZE_BITS-1:0]                     words [MICROPROG_LEN_WORDS];
  logic [IDX_W-1:0]                             nxt_idx;
  logic                                         last_word;

  for (genvar k = 0; k < MICROPROG_LEN_WORDS; k++) begin : g_words
    assign words[k] = entry[k*CMD_SIZE_BITS +: CMD_SIZE_BITS];
  end

  assign nxt_idx      = word_idx + IDX_W'(1);
  assign last_word    = (word_idx == IDX_W'(MICROPROG_LEN_WORDS - 1)) || cmd_data[CMD_SIZE_BITS-1];
  assign fifo_read_en = (state == FETCH);
  assign busy         = (state != IDLE);
  assign prog_done    = (state == DONE);

`ifdef SEQ_TIMEOUT_EN
  logic        error_q;
  logic [31:0] wait_cnt;
  assign error = error_q;
`else
  logic        unused_err_clr;
  logic [31:0] unused_timeout;
  assign unused_err_clr = err_clr;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign error          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      entry           <= '0;
      cmd_valid       <= 1'b0;
      cmd_data        <= '0;
      word_idx        <= '0;
      progs_completed <= '0;
`ifdef SEQ_TIMEOUT_EN
      error_q         <= 1'b0;
      wait_cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE:  if (enable && !fifo_empty) state <= FETCH;
        FETCH: state <= LOAD;
        LOAD: begin
          entry     <= fifo_read_data;
          word_idx  <= '0;
          cmd_data  <= fifo_read_data[CMD_SIZE_BITS-1:0];
          cmd_valid <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= WAIT;
`ifdef SEQ_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end
        WAIT: begin
          if (cmd_done) begin
            if (last_word) begin
              state <= DONE;
            end else begin
              word_idx  <= nxt_idx;
              cmd_data  <= words[nxt_idx];
              cmd_valid <= 1'b1;
              state     <= ISSUE;
            end
          end
`ifdef SEQ_TIMEOUT_EN
          // a done arriving on the limit cycle takes priority over the timeout
          else if (wait_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            error_q <= 1'b1;
            state   <= ERROR;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
`endif
        end
        DONE: begin
          progs_completed <= progs_completed + 16'd1;
          state           <= IDLE;
        end
        ERROR: begin
`ifdef SEQ_TIMEOUT_EN
          if (err_clr) begin
            error_q <= 1'b0;
            state   <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
